// File: rtl/delayed_start_counter.sv
// delayed_start_counter
//
// Delayed-start up-counter used as a start-up / settling timer. A start request
// arms a programmable wait of DELAY_CYCLES clocks, after which the counter runs
// from 0 to LIMIT and raises done. done gates downstream logic.
//
// Optional feature macro: DELAYED_START_COUNTER_AUTO_RESTART_EN
//   Defined   : DONE lasts one cycle, then the sequence re-arms by itself,
//               giving a periodic done pulse every DELAY_CYCLES+LIMIT+2 cycles.
//   Undefined : done is a sticky level held until start, abort or reset.
//
// Ports:
//   clk      in   1      sole clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      start / re-trigger request (honoured in IDLE and DONE)
//   abort    in   1      return to IDLE; wins over start on the same edge
//   count    out  WIDTH  current count value
//   busy     out  1      high in WAIT or COUNT
//   waiting  out  1      high in WAIT only
//   done     out  1      completion flag

module delayed_start_counter #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned LIMIT        = 10,
  parameter int unsigned DELAY_CYCLES = 5,
  // Derived; do not override.
  parameter int unsigned DLY_W        = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             waiting,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCount,
    StDone
  } state_e;

`ifdef DELAYED_START_COUNTER_AUTO_RESTART_EN
  localparam bit AutoRestart = 1'b1;
`else
  localparam bit AutoRestart = 1'b0;
`endif

  localparam logic [WIDTH-1:0] Limit   = WIDTH'(LIMIT);
  localparam logic [DLY_W-1:0] DlyLast = (DELAY_CYCLES == 0) ? '0 : DLY_W'(DELAY_CYCLES - 1);
  // With no delay the launch skips WAIT entirely.
  localparam state_e           StLaunch = (DELAY_CYCLES == 0) ? StCount : StWait;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dly_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    count_d = count_q;
    done_d  = done_q;

    if (abort) begin
      state_d = StIdle;
      dly_d   = '0;
      count_d = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dly_d   = '0;
            count_d = '0;
            state_d = StLaunch;
          end
        end
        StWait: begin
          dly_d = dly_q + DLY_W'(1);
          if (dly_q == DlyLast) begin
            state_d = StCount;
          end
        end
        StCount: begin
          if (count_q < Limit) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          // Re-trigger; in auto-restart builds this happens unconditionally.
          if (start || AutoRestart) begin
            dly_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            state_d = StLaunch;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == StWait) || (state_q == StCount);
  assign waiting = (state_q == StWait);
  assign done    = done_q;

endmodule

// File: tb/tb_delayed_start_counter.sv
// Testbench for delayed_start_counter. Two instances: the default configuration
// (WIDTH=4, LIMIT=10, DELAY_CYCLES=5) and a zero-delay variant. Stimulus pushes
// the expected post-edge outputs into a queue; a monitor pops and compares on
// each falling edge (or on demand for asynchronous-reset checks).
// Expected values follow the documented timing: n edges after start is sampled,
// n<D is WAIT, D<=n<=D+L is COUNT with count=n-D, later is DONE.

module tb_delayed_start_counter;

  localparam int L = 10;

  typedef struct {
    bit         sel;
    logic [3:0] count;
    logic       busy;
    logic       waiting;
    logic       done;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [3:0] count, count0;
  logic       busy, waiting, done;
  logic       busy0, waiting0, done0;

  exp_t q[$];
  bit   sel = 1'b0;
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  always #5 clk = ~clk;

  delayed_start_counter #(
    .WIDTH(4), .LIMIT(L), .DELAY_CYCLES(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .count(count), .busy(busy), .waiting(waiting), .done(done)
  );

  delayed_start_counter #(
    .WIDTH(4), .LIMIT(L), .DELAY_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
    .count(count0), .busy(busy0), .waiting(waiting0), .done(done0)
  );

  // Expected outputs n edges after the start was sampled; n<0 means idle.
  function automatic exp_t model(input int n, input int d, input bit s, input string tag);
    exp_t e;
    int   m;
    e.sel = s; e.tag = tag;
    e.count = 4'd0; e.busy = 1'b0; e.waiting = 1'b0; e.done = 1'b0;
    if (n >= 0) begin
      m = n;
`ifdef DELAYED_START_COUNTER_AUTO_RESTART_EN
      m = n % (d + L + 2);
`endif
      if (m < d) begin
        e.busy = 1'b1; e.waiting = 1'b1;
      end else if (m <= d + L) begin
        e.busy = 1'b1; e.count = 4'(m - d);
      end else begin
        e.count = 4'(L); e.done = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic tick(input bit s, input bit a, input int n, input string tag);
    start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    if (sel) begin start0 = s; abort0 = a; end
    else begin start = s; abort = a; end
    @(posedge clk);
    #1;
    q.push_back(model(n, sel ? 0 : 5, sel, tag));
  endtask

  task automatic cmp(input string tag, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d at %0t", tag, fld, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          cmp(e.tag, "count", int'(count0), int'(e.count));
          cmp(e.tag, "busy", int'(busy0), int'(e.busy));
          cmp(e.tag, "waiting", int'(waiting0), int'(e.waiting));
          cmp(e.tag, "done", int'(done0), int'(e.done));
        end else begin
          cmp(e.tag, "count", int'(count), int'(e.count));
          cmp(e.tag, "busy", int'(busy), int'(e.busy));
          cmp(e.tag, "waiting", int'(waiting), int'(e.waiting));
          cmp(e.tag, "done", int'(done), int'(e.done));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    sel = 1'b0;
    // Reset state
    tick(0, 0, -1, "reset");
    tick(0, 0, -1, "reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0, -1, "idle");

    // Nominal run, done held afterwards
    tick(1, 0, 0, "nominal");
    for (int n = 1; n <= 20; n++) tick(0, 0, n, "nominal");
    tick(0, 1, -1, "abort");

    // start held through WAIT and COUNT is ignored
    tick(1, 0, 0, "ign_start");
    for (int n = 1; n <= 16; n++) tick(1, 0, n, "ign_start");
    for (int n = 17; n <= 19; n++) tick(0, 0, n, "ign_start");
`ifndef DELAYED_START_COUNTER_AUTO_RESTART_EN
    // Re-trigger from DONE
    tick(1, 0, 0, "retrig");
    for (int n = 1; n <= 3; n++) tick(0, 0, n, "retrig");
`endif
    tick(0, 1, -1, "abort");

    // Abort with simultaneous start at edge 8, fresh start at edge 10
    tick(1, 0, 0, "abort_st");
    for (int n = 1; n <= 7; n++) tick(0, 0, n, "abort_st");
    tick(1, 1, -1, "abort_st");
    tick(0, 0, -1, "abort_st");
    tick(1, 0, 0, "abort_st");
    for (int n = 1; n <= 17; n++) tick(0, 0, n, "abort_st");
    tick(0, 1, -1, "abort");

    // Long run: sticky done, or periodic pulses with auto-restart; abort stops it
    tick(1, 0, 0, "long");
    for (int n = 1; n <= 40; n++) tick(0, 0, n, "long");
    tick(0, 1, -1, "long_abort");
    for (int i = 0; i < 20; i++) tick(0, 0, -1, "long_idle");

    // Asynchronous reset mid-COUNT (count=6)
    tick(1, 0, 0, "async_rst");
    for (int n = 1; n <= 11; n++) tick(0, 0, n, "async_rst");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    q.push_back(model(-1, 5, 1'b0, "async_rst_now"));
    ->sample_ev;
    tick(0, 0, -1, "rst_held");
    tick(0, 0, -1, "rst_held");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(0, 0, -1, "post_rst_idle");

    // Zero-delay instance
    sel = 1'b1;
    tick(1, 0, 0, "zero_dly");
    for (int n = 1; n <= 13; n++) tick(0, 0, n, "zero_dly");
`ifndef DELAYED_START_COUNTER_AUTO_RESTART_EN
    tick(1, 0, 0, "zero_retrig");
    for (int n = 1; n <= 12; n++) tick(0, 0, n, "zero_retrig");
`else
    for (int n = 14; n <= 30; n++) tick(0, 0, n, "zero_dly");
`endif
    tick(0, 1, -1, "zero_abort");
    tick(0, 0, -1, "zero_idle");

    // Let the monitor drain the queue
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delayed_start_counter.md
# delayed_start_counter

Parametrised delayed-start up-counter: on a start request it waits a programmable number of clock cycles, then counts from 0 to a programmable limit and flags completion. It generalises the fixed "wait 5 cycles, count to 10" start-up sequencer. It adds width/limit/delay parameters, explicit start/abort control, re-triggering, and an optional auto-restart mode. It sits beside the datapath as a start-up/settling timer whose `done` gates downstream logic.

## Interface
- `WIDTH`, 4: count register width.
- `LIMIT`, 10: terminal count value; legal range 1 ≤ LIMIT ≤ 2**WIDTH−1.
- `DELAY_CYCLES`, 5: wait cycles between start and the first count cycle; 0 is legal.
- `DLY_W`, $clog2(DELAY_CYCLES+1) (minimum 1): delay counter width; derived, do not override.

- `clk`  in  1  sole clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request, sampled on each rising edge.
- `abort`  in  1  return to IDLE, sampled on each rising edge.
- `count`  out  WIDTH  current count value.
- `busy`  out  1  high in WAIT or COUNT.
- `waiting`  out  1  high in WAIT only.
- `done`  out  1  completion flag.

## Operation
- FSM states are IDLE, WAIT, COUNT and DONE. All outputs are registered or decoded from registered state.
- **Reset:** state=IDLE, `count`=0, delay counter=0, `done`=0, `busy`=0, `waiting`=0.
- **IDLE:**
  - If `start`=1: delay counter←0 and `count`←0.
  - Go to WAIT, or go straight to COUNT when DELAY_CYCLES=0.
- **WAIT:**
  - Delay counter increments each edge.
  - When it equals DELAY_CYCLES−1, go to COUNT.
  - WAIT lasts exactly DELAY_CYCLES cycles.
- **COUNT:**
  - If `count` < LIMIT: `count`←`count`+1.
  - Otherwise go to DONE and set `done`←1. `count` holds at LIMIT.
- **DONE:**
  - `done` stays 1 and `count` holds LIMIT.
  - If `start`=1: `done`←0, `count`←0, then enter WAIT, or COUNT when DELAY_CYCLES=0 (re-trigger).
- `start` is ignored in WAIT and COUNT. No re-trigger while busy.
- `abort`=1 in any state: next state IDLE, `count`←0, `done`←0, delay counter←0.
- `abort` has priority over `start` on the same edge.
- Count arithmetic is unsigned WIDTH-bit. The LIMIT bound guarantees no wrap-around.
- Asynchronous reset mid-operation: all outputs reach their reset values immediately, without waiting for an edge. After `reset_n` deasserts, the block requires a new `start`.

## Timing
- Let `start` be sampled at edge k (IDLE or DONE).
- `busy`=1 after edge k. `waiting`=1 for edges k+1 … k+DELAY_CYCLES.
- First increment (`count`=1) at edge k+DELAY_CYCLES+1.
- `count`=LIMIT at edge k+DELAY_CYCLES+LIMIT.
- `done`=1 and `busy`=0 after edge k+DELAY_CYCLES+LIMIT+1.
- Start-to-done latency is DELAY_CYCLES+LIMIT+1 cycles.
- `abort` takes effect on the next edge: `busy`=0 and `count`=0 one cycle after it is sampled.
- `reset_n` deassertion is synchronised externally. The block assumes it is released glitch-free relative to `clk`.

## Configuration
- Macro: `DELAYED_START_COUNTER_AUTO_RESTART_EN`.
- **Defined:**
  - DONE lasts exactly one cycle, so `done` is a one-cycle pulse.
  - On the next edge the FSM re-enters WAIT (or COUNT when DELAY_CYCLES=0) with `count`←0, without needing `start`. This gives a periodic tick of period DELAY_CYCLES+LIMIT+2 cycles.
  - `abort` still returns the FSM to IDLE.
- **Undefined:** `done` is a sticky level held until `start`, `abort` or reset.

## Test plan
- **Reset:** assert `reset_n`=0 mid-COUNT (`count`=6) → `count`=0, `done`=0, `busy`=0 immediately. After release the block stays IDLE for 20 cycles with no `start`.
- **Nominal run** (WIDTH=4, LIMIT=10, DELAY_CYCLES=5): `start` pulse at edge 0 → `waiting` high for edges 1–5, `count`=1 at edge 6, `count`=10 at edge 15, `done`=1 after edge 16 and held.
- **Ignored start:** `start` held high through WAIT and COUNT → no restart; timing identical to the nominal run.
- **Abort plus simultaneous start:** `abort`=1 and `start`=1 at edge 8 → IDLE, `count`=0 after edge 8. A fresh `start` at edge 10 yields `done` after edge 26.
- **Re-trigger and zero delay:** with DELAY_CYCLES=0, `start` at edge 0 → `count`=1 at edge 1 and `done` after edge 11. `start` in DONE → `done`=0 and `count`=0 on the next edge, then a repeat run.
- **Auto-restart** (macro defined, LIMIT=10, DELAY_CYCLES=5): `done` pulses one cycle every 17 cycles without further `start`. `abort` stops the pulses.
